wb_ctrl_fsm: RTL
================

Name: wb_ctrl_fsm

Overview:
- Multi-cycle control sequencer that drives the 3-bit writeback select consumed by the writeback mux.
  - Encodings: ALU 000, load 001, PC+4 010, PC+IMM 011, IMM 100.
- Accepts one instruction opcode per handshake and steps through DECODE/EXEC/MEM/WB.
- Issues memory request handshakes and asserts register/PC write enables in the correct cycle.
- Sits between the instruction register and the datapath (ALU, data memory port, regfile, writeback mux).

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before abort (>=1).
- CNT_W, 5, width of timeout counter; must satisfy 2**CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  opcode valid from fetch.
- instr_ready  output  1  FSM can accept an opcode.
- opcode  input  7  RV32I opcode field, sampled on handshake.
- mem_req  output  1  data memory request, held until mem_ready.
- mem_we  output  1  1 = store, 0 = load; valid while mem_req.
- mem_ready  input  1  memory completes the request this cycle.
- reg_we  output  1  register file write enable.
- wb_sel  output  3  writeback mux select.
- pc_we  output  1  PC update strobe (one cycle per retired/aborted instruction).
- illegal_instr  output  1  one-cycle pulse on unknown opcode.
- mem_err  output  1  one-cycle pulse on memory timeout.
- instret  output  32  retired-instruction count (see Optional Feature).

Behaviour:
- States: IDLE, DECODE, EXEC, MEM, WB.
- Reset (async, any state): state=IDLE, wb_sel=000, latched class=ALU, timeout count=0, instret=0. All strobes (mem_req, mem_we, reg_we, pc_we, illegal_instr, mem_err) are 0.
- IDLE: instr_ready=1 only here. On instr_valid&&instr_ready, latch opcode and go to DECODE. Otherwise stay.
- DECODE: classify the latched opcode.
  - 0110011/0010011 -> ALU, sel 000, writes.
  - 0000011 -> LOAD, sel 001, writes.
  - 0100011 -> STORE, no write.
  - 1100011 -> BRANCH, no write.
  - 1101111/1100111 -> JUMP, sel 010, writes.
  - 0010111 -> AUIPC, sel 011, writes.
  - 0110111 -> LUI, sel 100, writes.
  - Any other opcode: illegal_instr=1 and pc_we=1 for this cycle, then IDLE.
  - Legal opcode: go to EXEC.
- EXEC: one cycle. LOAD/STORE go to MEM; all others go to WB.
- MEM:
  - mem_req=1 every cycle in this state; mem_we=1 for STORE, 0 for LOAD.
  - Counter increments each cycle mem_ready=0.
  - mem_ready=1 -> LOAD goes to WB; STORE pulses pc_we and goes to IDLE (counts as retired).
  - Counter reaches MEM_TIMEOUT with mem_ready=0 -> mem_err=1 and pc_we=1 that cycle, then IDLE. Aborted instruction is not retired.
  - mem_ready and the timeout in the same cycle: completion wins.
- WB: one cycle. pc_we=1; reg_we=1 for writing classes; wb_sel = class encoding. Then IDLE.
- wb_sel update rule:
  - Registered. Updated on DECODE->EXEC only and held until the next legal decode.
  - Stable from EXEC through WB so the mux output is settled at reg_we.
- Timing: min latency handshake->WB is 3 cycles (DECODE, EXEC, WB). Loads take 4+N cycles, where N = mem_ready wait cycles.
- instr_valid outside IDLE is ignored. No opcode is buffered.

Optional Feature:
- Macro WB_CTRL_INSTRET_EN.
- Defined:
  - instret increments by 1 on each retirement: the WB cycle, or STORE completion.
  - Wraps modulo 2**32.
  - Illegal and aborted instructions are not counted.
- Undefined: instret tied to 32'd0 and no counter logic is present.

Decomposition:
- Shared package wb_ctrl_pkg:
  - opcode localparams.
  - WB_SEL_ALU/LOAD/PC4/PCIMM/IMM 3-bit constants, matching the writeback mux encoding exactly.
  - State enum.
  - Instruction-class enum.
- One natural sub-module: opcode_classifier. Combinational opcode -> {class, wb_sel, writes, legal}.

Test Plan:
- Reset mid-MEM (rst asserted while mem_req=1) -> same cycle: mem_req=0, state IDLE, wb_sel=000, instr_ready=1.
- opcode 0110011 handshake, no stalls -> reg_we=1, wb_sel=000, pc_we=1 exactly 3 cycles after handshake; instr_ready high again the next cycle.
- opcode 0000011, mem_ready after 2 wait cycles -> mem_req high 3 cycles, mem_we=0. Then WB with wb_sel=001, reg_we=1.
- opcode 0100011, mem_ready never asserted, MEM_TIMEOUT=16 -> mem_err pulse after 16 cycles in MEM; reg_we never asserted; instret unchanged.
- opcode 1111111 -> illegal_instr and pc_we pulse in DECODE cycle; no mem_req, no reg_we; wb_sel retains previous value.
- Sequence LUI, AUIPC, JAL, BEQ -> wb_sel 100, 011, 010 with reg_we=1 each; BEQ gives reg_we=0. With WB_CTRL_INSTRET_EN, instret=4.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// Shared constants and types for the writeback control sequencer:
// RV32I opcode values, writeback mux encodings, FSM states and instruction classes.
package wb_ctrl_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Must match the writeback mux input ordering exactly.
  localparam logic [2:0] WB_SEL_ALU   = 3'b000;
  localparam logic [2:0] WB_SEL_LOAD  = 3'b001;
  localparam logic [2:0] WB_SEL_PC4   = 3'b010;
  localparam logic [2:0] WB_SEL_PCIMM = 3'b011;
  localparam logic [2:0] WB_SEL_IMM   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JUMP,
    CL_AUIPC,
    CL_LUI
  } iclass_t;

endpackage

// File: rtl/wb_ctrl_fsm_classifier.sv
// Combinational opcode decoder: maps an RV32I opcode to its instruction class,
// writeback select, register-write flag and legality.
module opcode_classifier
  import wb_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls,
  output logic [2:0] sel,
  output logic       writes,
  output logic       legal
);

  always_comb begin
    cls    = CL_ALU;
    sel    = WB_SEL_ALU;
    writes = 1'b0;
    legal  = 1'b1;
    case (opcode)
      OP_OP, OP_IMM: begin
        cls    = CL_ALU;
        writes = 1'b1;
      end
      OP_LOAD: begin
        cls    = CL_LOAD;
        sel    = WB_SEL_LOAD;
        writes = 1'b1;
      end
      OP_STORE:  cls = CL_STORE;
      OP_BRANCH: cls = CL_BRANCH;
      OP_JAL, OP_JALR: begin
        cls    = CL_JUMP;
        sel    = WB_SEL_PC4;
        writes = 1'b1;
      end
      OP_AUIPC: begin
        cls    = CL_AUIPC;
        sel    = WB_SEL_PCIMM;
        writes = 1'b1;
      end
      OP_LUI: begin
        cls    = CL_LUI;
        sel    = WB_SEL_IMM;
        writes = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_ctrl_fsm.sv
// Multi-cycle DECODE/EXEC/MEM/WB control sequencer driving the writeback select,
// memory handshake and write strobes. Define WB_CTRL_INSTRET_EN for the retire counter.
module wb_ctrl_fsm
  import wb_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [6:0]  opcode,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        reg_we,
  output logic [2:0]  wb_sel,
  output logic        pc_we,
  output logic        illegal_instr,
  output logic        mem_err,
  output logic [31:0] instret
);

  state_t             state, state_nxt;
  logic [6:0]         op_q;
  iclass_t            cls_q;
  logic               writes_q;
  logic [2:0]         wb_sel_q;
  logic [CNT_W-1:0]   cnt;

  iclass_t            dec_cls;
  logic [2:0]         dec_sel;
  logic               dec_writes;
  logic               dec_legal;
  logic               timeout;
  logic               is_store;

  opcode_classifier u_classifier (
    .opcode (op_q),
    .cls    (dec_cls),
    .sel    (dec_sel),
    .writes (dec_writes),
    .legal  (dec_legal)
  );

  // Completion on the final allowed cycle beats the abort.
  assign timeout  = (cnt == CNT_W'(MEM_TIMEOUT - 1)) && !mem_ready;
  assign is_store = (cls_q == CL_STORE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (instr_valid) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = dec_legal ? ST_EXEC : ST_IDLE;
      ST_EXEC:   state_nxt = (cls_q == CL_LOAD || cls_q == CL_STORE) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (mem_ready)    state_nxt = is_store ? ST_IDLE : ST_WB;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_WB:     state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready   = (state == ST_IDLE);
    mem_req       = (state == ST_MEM);
    mem_we        = (state == ST_MEM) && is_store;
    reg_we        = (state == ST_WB) && writes_q;
    illegal_instr = (state == ST_DECODE) && !dec_legal;
    mem_err       = (state == ST_MEM) && timeout;
    pc_we         = illegal_instr || mem_err || (state == ST_WB)
                 || ((state == ST_MEM) && mem_ready && is_store);
  end

  // Opcode is plain data and only meaningful after a handshake.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && instr_valid) op_q <= opcode;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q    <= CL_ALU;
      writes_q <= 1'b0;
      wb_sel_q <= WB_SEL_ALU;
    end else if (state == ST_DECODE && dec_legal) begin
      cls_q    <= dec_cls;
      writes_q <= dec_writes;
      wb_sel_q <= dec_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        cnt <= '0;
    else if (state == ST_MEM && state_nxt == ST_MEM) cnt <= cnt + 1'b1;
    else                                            cnt <= '0;
  end

  assign wb_sel = wb_sel_q;

`ifdef WB_CTRL_INSTRET_EN
  logic        retire;
  logic [31:0] instret_q;

  assign retire = (state == ST_WB) || ((state == ST_MEM) && mem_ready && is_store);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule
